// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hold/bubble/clear sequencing for the 5-stage RV32IC core.
// Perf counters built only with PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned LU_BUBBLES  = 1,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_l1,
  input  logic [4:0]       rs1_l1,
  input  logic [4:0]       rs2_l1,
  input  logic             rs1_used_l1,
  input  logic             rs2_used_l1,
  input  logic             valid_l2,
  input  logic [4:0]       rd_l2,
  input  logic             load_l2,
  input  logic             jump_en_l2,
  input  logic             mem_req_l3,
  input  logic             mem_ready_l3,
  output logic             stall_pc,
  output logic             stall_l1,
  output logic             stall_l2,
  output logic             stall_l3,
  output logic             bubble_l2,
  output logic             clear_l1,
  output logic             clear_l2,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] lu_cnt
);

  typedef enum logic [1:0] {
    RUN,
    LDUSE,
    MEMWAIT
  } state_e;

  localparam logic [1:0]  BINIT = 2'(LU_BUBBLES - 1);
  localparam logic [15:0] TO_MX = 16'(MEM_TIMEOUT);
  localparam logic [15:0] TO_M1 = 16'(MEM_TIMEOUT - 1);
  localparam bit          MULTI = (LU_BUBBLES > 1);

  state_e      state_q;
  state_e      ret_q;
  state_e      eff;
  logic [1:0]  bcnt_q;
  logic [15:0] wcnt_q;
  logic        to_q;

  logic        rs1_hit;
  logic        rs2_hit;
  logic        lu_hz;
  logic        mem_stall;
  logic        lu_go;
  logic        lu_on;
  logic        to_hit;

  assign rs1_hit = rs1_used_l1 & (rs1_l1 == rd_l2);
  assign rs2_hit = rs2_used_l1 & (rs2_l1 == rd_l2);
  assign lu_hz = valid_l1 & valid_l2 & load_l2
               & (rd_l2 != 5'd0) & (rs1_hit | rs2_hit);

  assign mem_stall = mem_req_l3 & ~mem_ready_l3;

  // On the release cycle MEMWAIT already behaves as the saved state.
  assign eff = (state_q == MEMWAIT) ? ret_q : state_q;

  assign lu_go = ~mem_stall & ~jump_en_l2
               & (eff == RUN) & lu_hz;
  assign lu_on = lu_go | (~mem_stall & ~jump_en_l2
               & (eff == LDUSE));

  assign to_hit = mem_stall & (wcnt_q >= TO_M1);

  always_comb begin
    stall_pc  = 1'b0;
    stall_l1  = 1'b0;
    stall_l2  = 1'b0;
    stall_l3  = 1'b0;
    bubble_l2 = 1'b0;
    clear_l1  = 1'b0;
    clear_l2  = 1'b0;
    if (rst) begin
      clear_l1 = 1'b1;
      clear_l2 = 1'b1;
    end else if (mem_stall) begin
      stall_pc = 1'b1;
      stall_l1 = 1'b1;
      stall_l2 = 1'b1;
      stall_l3 = 1'b1;
    end else if (jump_en_l2) begin
      clear_l1 = 1'b1;
      clear_l2 = 1'b1;
    end else if (lu_on) begin
      stall_pc  = 1'b1;
      stall_l1  = 1'b1;
      bubble_l2 = 1'b1;
    end
  end

  assign mem_timeout = ~rst & (to_q | to_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      bcnt_q  <= 2'd0;
      wcnt_q  <= 16'd0;
      to_q    <= 1'b0;
    end else begin
      to_q <= to_q | to_hit;
      if (mem_stall) begin
        if (wcnt_q != TO_MX) begin
          wcnt_q <= wcnt_q + 16'd1;
        end
      end else begin
        wcnt_q <= 16'd0;
      end

      if (mem_stall) begin
        state_q <= MEMWAIT;
        if (state_q != MEMWAIT) begin
          ret_q <= state_q;
        end
      end else if (jump_en_l2) begin
        state_q <= RUN;
        ret_q   <= RUN;
        bcnt_q  <= 2'd0;
      end else begin
        unique case (eff)
          LDUSE: begin
            bcnt_q  <= bcnt_q - 2'd1;
            state_q <= (bcnt_q == 2'd1) ? RUN : LDUSE;
          end
          default: begin
            if (lu_hz && MULTI) begin
              bcnt_q  <= BINIT;
              state_q <= LDUSE;
            end else begin
              state_q <= RUN;
            end
          end
        endcase
      end
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] lu_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      if (stall_pc) begin
        stall_cnt_q <= stall_cnt_q + ONE;
      end
      if (jump_en_l2 & ~mem_stall) begin
        flush_cnt_q <= flush_cnt_q + ONE;
      end
      if (lu_go) begin
        lu_cnt_q <= lu_cnt_q + ONE;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign lu_cnt    = lu_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign lu_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: three instances with LU_BUBBLES = 1, 2, 3
// driven by shared inputs; expected control vectors computed by hand.
module tb_pipe_hazard_ctrl;

  // ctrl = {stall_pc, stall_l1, stall_l2, stall_l3, bubble_l2, clear_l1, clear_l2}
  localparam logic [6:0] C0 = 7'b0000000;
  localparam logic [6:0] CL = 7'b1100100;
  localparam logic [6:0] CM = 7'b1111000;
  localparam logic [6:0] CF = 7'b0000011;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_l1;
  logic [4:0] rs1_l1;
  logic [4:0] rs2_l1;
  logic       rs1_used_l1;
  logic       rs2_used_l1;
  logic       valid_l2;
  logic [4:0] rd_l2;
  logic       load_l2;
  logic       jump_en_l2;
  logic       mem_req_l3;
  logic       mem_ready_l3;

  logic [6:0]  c1, c2, c3;
  logic        mt1, mt2, mt3;
  logic [31:0] sc1, sc2, sc3;
  logic [31:0] fc1, fc2, fc3;
  logic [31:0] lc1, lc2, lc3;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LU_BUBBLES(1), .MEM_TIMEOUT(8)) u_d1 (
    .clk(clk), .rst(rst),
    .valid_l1(valid_l1), .rs1_l1(rs1_l1), .rs2_l1(rs2_l1),
    .rs1_used_l1(rs1_used_l1), .rs2_used_l1(rs2_used_l1),
    .valid_l2(valid_l2), .rd_l2(rd_l2), .load_l2(load_l2),
    .jump_en_l2(jump_en_l2), .mem_req_l3(mem_req_l3),
    .mem_ready_l3(mem_ready_l3),
    .stall_pc(c1[6]), .stall_l1(c1[5]), .stall_l2(c1[4]),
    .stall_l3(c1[3]), .bubble_l2(c1[2]),
    .clear_l1(c1[1]), .clear_l2(c1[0]),
    .mem_timeout(mt1),
    .stall_cnt(sc1), .flush_cnt(fc1), .lu_cnt(lc1)
  );

  pipe_hazard_ctrl #(.LU_BUBBLES(2)) u_d2 (
    .clk(clk), .rst(rst),
    .valid_l1(valid_l1), .rs1_l1(rs1_l1), .rs2_l1(rs2_l1),
    .rs1_used_l1(rs1_used_l1), .rs2_used_l1(rs2_used_l1),
    .valid_l2(valid_l2), .rd_l2(rd_l2), .load_l2(load_l2),
    .jump_en_l2(jump_en_l2), .mem_req_l3(mem_req_l3),
    .mem_ready_l3(mem_ready_l3),
    .stall_pc(c2[6]), .stall_l1(c2[5]), .stall_l2(c2[4]),
    .stall_l3(c2[3]), .bubble_l2(c2[2]),
    .clear_l1(c2[1]), .clear_l2(c2[0]),
    .mem_timeout(mt2),
    .stall_cnt(sc2), .flush_cnt(fc2), .lu_cnt(lc2)
  );

  pipe_hazard_ctrl #(.LU_BUBBLES(3)) u_d3 (
    .clk(clk), .rst(rst),
    .valid_l1(valid_l1), .rs1_l1(rs1_l1), .rs2_l1(rs2_l1),
    .rs1_used_l1(rs1_used_l1), .rs2_used_l1(rs2_used_l1),
    .valid_l2(valid_l2), .rd_l2(rd_l2), .load_l2(load_l2),
    .jump_en_l2(jump_en_l2), .mem_req_l3(mem_req_l3),
    .mem_ready_l3(mem_ready_l3),
    .stall_pc(c3[6]), .stall_l1(c3[5]), .stall_l2(c3[4]),
    .stall_l3(c3[3]), .bubble_l2(c3[2]),
    .clear_l1(c3[1]), .clear_l2(c3[0]),
    .mem_timeout(mt3),
    .stall_cnt(sc3), .flush_cnt(fc3), .lu_cnt(lc3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [6:0] e1,
                      input logic [6:0] e2, input logic [6:0] e3);
    chk({tag, "_d1"}, 32'(c1), 32'(e1));
    chk({tag, "_d2"}, 32'(c2), 32'(e2));
    chk({tag, "_d3"}, 32'(c3), 32'(e3));
  endtask

  task automatic perf(input string tag,
                      input int s1, input int s2, input int s3,
                      input int f, input int l);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    chk({tag, "_stall1"}, sc1, 32'(s1));
    chk({tag, "_stall2"}, sc2, 32'(s2));
    chk({tag, "_stall3"}, sc3, 32'(s3));
    chk({tag, "_flush"}, fc1, 32'(f));
    chk({tag, "_lu"}, lc3, 32'(l));
`else
    chk({tag, "_stall_tied"}, sc3 | sc2 | sc1, 32'(s1 & 0));
    chk({tag, "_flush_tied"}, fc3 | fc1, 32'(f & 0));
    chk({tag, "_lu_tied"}, lc3 | lc1, 32'(l & 0));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_l1     = 1'b0;
    rs1_l1       = 5'd0;
    rs2_l1       = 5'd0;
    rs1_used_l1  = 1'b0;
    rs2_used_l1  = 1'b0;
    valid_l2     = 1'b0;
    rd_l2        = 5'd0;
    load_l2      = 1'b0;
    jump_en_l2   = 1'b0;
    mem_req_l3   = 1'b0;
    mem_ready_l3 = 1'b0;
  endtask

  task automatic haz(input logic v1, input logic [4:0] r1,
                     input logic u1, input logic [4:0] r2,
                     input logic u2, input logic v2,
                     input logic [4:0] rd, input logic ld);
    valid_l1    = v1;
    rs1_l1      = r1;
    rs1_used_l1 = u1;
    rs2_l1      = r2;
    rs2_used_l1 = u2;
    valid_l2    = v2;
    rd_l2       = rd;
    load_l2     = ld;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    #2;
    chk3("rst", CF, CF, CF);
    chk("rst_mt", 32'(mt1), 32'd0);
    perf("rst", 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    #2;
    chk3("idle", C0, C0, C0);
    tick();

    // lw x5 ; add x6,x5,x1
    haz(1'b1, 5'd5, 1'b1, 5'd1, 1'b0, 1'b1, 5'd5, 1'b1);
    #2; chk3("lu_c0", CL, CL, CL); tick();
    idle();
    #2; chk3("lu_c1", C0, CL, CL); tick();
    #2; chk3("lu_c2", C0, C0, CL); tick();
    #2; chk3("lu_c3", C0, C0, C0); tick();
    perf("lu", 1, 2, 3, 0, 1);
    rst_pulse();

    haz(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1);
    #2; chk3("x0", C0, C0, C0); tick();
    haz(1'b1, 5'd5, 1'b0, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1);
    #2; chk3("rs1_unused", C0, C0, C0); tick();
    haz(1'b1, 5'd3, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1);
    #2; chk3("rs2_hit", CL, CL, CL); tick();
    rst_pulse();
    haz(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1);
    #2; chk3("l2_bubble", C0, C0, C0); tick();
    haz(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0);
    #2; chk3("not_load", C0, C0, C0); tick();
    idle();
    rst_pulse();

    // memory wait with pending redirect
    for (int i = 0; i < 4; i++) begin
      mem_req_l3 = 1'b1; mem_ready_l3 = 1'b0; jump_en_l2 = 1'b1;
      #2; chk3($sformatf("memj_w%0d", i), CM, CM, CM); tick();
    end
    mem_ready_l3 = 1'b1;
    #2; chk3("memj_rdy", CF, CF, CF); tick();
    idle();
    #2; chk3("memj_after", C0, C0, C0); tick();
    perf("memj", 4, 4, 4, 1, 0);
    rst_pulse();

    // load-use and redirect together
    haz(1'b1, 5'd5, 1'b1, 5'd1, 1'b0, 1'b1, 5'd5, 1'b1);
    jump_en_l2 = 1'b1;
    #2; chk3("luj", CF, CF, CF); tick();
    idle();
    #2; chk3("luj_after", C0, C0, C0); tick();
    perf("luj", 0, 0, 0, 1, 0);
    rst_pulse();

    // memory wait interrupting LDUSE
    haz(1'b1, 5'd5, 1'b1, 5'd1, 1'b0, 1'b1, 5'd5, 1'b1);
    #2; chk3("lum_c0", CL, CL, CL); tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      mem_req_l3 = 1'b1; mem_ready_l3 = 1'b0;
      #2; chk3($sformatf("lum_w%0d", i), CM, CM, CM); tick();
    end
    mem_ready_l3 = 1'b1;
    #2; chk3("lum_rdy", C0, CL, CL); tick();
    idle();
    #2; chk3("lum_c5", C0, C0, CL); tick();
    #2; chk3("lum_c6", C0, C0, C0); tick();
    perf("lum", 4, 5, 6, 0, 1);
    rst_pulse();

    // timeout on d1 (MEM_TIMEOUT = 8)
    for (int k = 1; k <= 10; k++) begin
      mem_req_l3 = 1'b1; mem_ready_l3 = 1'b0;
      #2;
      chk($sformatf("to_ctrl%0d", k), 32'(c1), 32'(CM));
      chk($sformatf("to_mt1_%0d", k), 32'(mt1), 32'(k >= 8));
      chk($sformatf("to_mt2_%0d", k), 32'(mt2), 32'd0);
      tick();
    end
    idle();
    #2;
    chk("to_sticky", 32'(mt1), 32'd1);
    chk3("to_release", C0, C0, C0);
    tick();
    mem_req_l3 = 1'b1; mem_ready_l3 = 1'b0;
    #2; chk("to_sticky2", 32'(mt1), 32'd1); tick();
    rst = 1'b1;
    #2;
    chk3("to_rst", CF, CF, CF);
    chk("to_rst_mt", 32'(mt1), 32'd0);
    tick();
    #2;
    chk3("to_rst2", CF, CF, CF);
    chk("to_rst2_mt", 32'(mt1), 32'd0);
    tick();
    rst = 1'b0;
    idle();
    #2;
    chk3("to_post", C0, C0, C0);
    chk("to_post_mt", 32'(mt1), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
